// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
//
// Purpose:
//   Sequential shift-add multiplier. One WIDTH x WIDTH product is formed over
//   WIDTH compute steps using a single 2*WIDTH-bit adder and shift registers
//   rather than a combinational partial-product array. It trades latency for
//   area.
//
//   Accept at edge 0. Edges 1..WIDTH perform the shift-add steps. Edge
//   WIDTH+1 registers the (optionally negated) product and enters DONE. The
//   minimum initiation interval is WIDTH+3 cycles.
//
// Optional feature (compile-time macro): SEQ_MULT_SIGNED_EN
//   defined   : is_signed selects two's-complement operation for each operand
//               pair. The magnitudes are multiplied and the result is negated
//               when the operand signs differ.
//   undefined : every operation is unsigned. is_signed is kept only for pin
//               compatibility.
//
// Handshakes (both sides, strict valid/ready):
//   A transfer happens on a rising edge where valid && ready are both high.
//   While valid is high and ready is low, the producer holds its data stable.
//   Input side : in_ready is high only in IDLE. in_valid seen in other states
//                is ignored and its operands are not captured.
//   Output side: out_valid and product stay stable in DONE until out_ready.
//
// Ports:
//   clk        in   1         rising-edge clock
//   rst        in   1         synchronous active-high reset (aborts any op)
//   in_valid   in   1         operands/mode valid
//   in_ready   out  1         ready to accept operands (IDLE only)
//   a          in   WIDTH     multiplicand
//   b          in   WIDTH     multiplier
//   is_signed  in   1         1 = two's-complement op (when feature enabled)
//   out_valid  out  1         product valid, held until taken
//   out_ready  in   1         consumer accepts product
//   product    out  2*WIDTH   result, changes only on DONE entry or reset
//   busy       out  1         high in CALC or DONE
//   o_state    out  2         FSM state for observation (0 IDLE, 1 CALC, 2 DONE)
// ---------------------------------------------------------------------------
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic [1:0]           o_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // The counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]           r_state;
  logic [2*WIDTH-1:0]   r_mcand;    // multiplicand, shifted left each step
  logic [WIDTH-1:0]     r_mplier;   // multiplier, shifted right each step
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_count;    // steps remaining
  logic [2*WIDTH-1:0]   r_product;

  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [2*WIDTH-1:0]   w_result;
  logic                 w_accept;
  logic                 w_take;

`ifdef SEQ_MULT_SIGNED_EN
  logic r_neg;
  logic w_neg;

  // Magnitude of the most negative value fits because it is read back as an
  // unsigned WIDTH-bit number (e.g. -128 -> 8'h80 = 128).
  assign w_a_mag  = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign w_b_mag  = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  assign w_neg    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
  // Negating zero gives zero, so a zero operand never yields a "-0" result.
  assign w_result = r_neg ? (~r_acc + (2*WIDTH)'(1)) : r_acc;
`else
  logic w_unused_is_signed;

  assign w_unused_is_signed = is_signed;
  assign w_a_mag            = a;
  assign w_b_mag            = b;
  assign w_result           = r_acc;
`endif

  assign w_accept  = in_valid  && (r_state == S_IDLE);
  assign w_take    = out_ready && (r_state == S_DONE);

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign product   = r_product;
  assign o_state   = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_product <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      r_neg     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_acc    <= '0;
            r_count  <= CW'(WIDTH);
`ifdef SEQ_MULT_SIGNED_EN
            r_neg    <= w_neg;
`endif
            r_state  <= S_CALC;
          end
        end

        S_CALC: begin
          if (r_count != '0) begin
            if (r_mplier[0]) begin
              r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count - CW'(1);
          end else begin
            // All steps are done. Register the final (sign-corrected)
            // product on the way into DONE.
            r_product <= w_result;
            r_state   <= S_DONE;
          end
        end

        S_DONE: begin
          if (w_take) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

  logic clk;
  logic rst;

  int n_checks;
  int n_errors;

  // WIDTH=8 instance
  logic        v8, rdy8, s8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic [1:0]  st8;

  // WIDTH=4 instance
  logic        v4, rdy4, s4, ov4, or4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
  logic [1:0]  st4;

  // WIDTH=16 instance
  logic        v16, rdy16, s16, ov16, or16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] p16;
  logic [1:0]  st16;

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .a(a8), .b(b8),
    .is_signed(s8), .out_valid(ov8), .out_ready(or8), .product(p8),
    .busy(busy8), .o_state(st8)
  );

  seq_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .a(a4), .b(b4),
    .is_signed(s4), .out_valid(ov4), .out_ready(or4), .product(p4),
    .busy(busy4), .o_state(st4)
  );

  seq_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .a(a16), .b(b16),
    .is_signed(s16), .out_valid(ov16), .out_ready(or16), .product(p16),
    .busy(busy16), .o_state(st16)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Presents one operand pair to the 8-bit DUT and waits for out_valid.
  // lat counts rising edges from the accept edge to the first out_valid.
  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic s,
                     output logic [15:0] prod, output int lat);
    @(negedge clk);
    chk("w8_in_ready_idle", {63'b0, rdy8}, 64'd1);
    a8 = ia; b8 = ib; s8 = s; v8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    prod = p8;
  endtask

  task automatic op4(input logic [3:0] ia, input logic [3:0] ib);
    int lat;
    @(negedge clk);
    a4 = ia; b4 = ib; v4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v4 = 1'b0;
    lat = 0;
    while (!ov4 && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    exp_q.push_back({24'd0, {4'd0, ia} * {4'd0, ib}});
    chk("w4_product", {56'd0, p4}, {32'd0, exp_q.pop_front()});
    chk("w4_latency", 64'(lat), 64'd5);
  endtask

  task automatic op16(input logic [15:0] ia, input logic [15:0] ib);
    int lat;
    @(negedge clk);
    a16 = ia; b16 = ib; v16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v16 = 1'b0;
    lat = 0;
    while (!ov16 && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    exp_q.push_back({16'd0, ia} * {16'd0, ib});
    chk("w16_product", {32'd0, p16}, {32'd0, exp_q.pop_front()});
    chk("w16_latency", 64'(lat), 64'd17);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [15:0] prod;
    int          lat;

    n_checks = 0;
    n_errors = 0;
    v8 = 0; a8 = 0; b8 = 0; s8 = 0; or8 = 1;
    v4 = 0; a4 = 0; b4 = 0; s4 = 0; or4 = 1;
    v16 = 0; a16 = 0; b16 = 0; s16 = 0; or16 = 1;

    vecs[0] = '{a: 8'd13,  b: 8'd11,  s: 1'b0, exp: 16'h008F};
    vecs[1] = '{a: 8'd255, b: 8'd255, s: 1'b0, exp: 16'hFE01};
    vecs[2] = '{a: 8'd0,   b: 8'd200, s: 1'b0, exp: 16'h0000};
    vecs[3] = '{a: 8'hFD,  b: 8'h05,  s: 1'b0, exp: 16'h04F1};
`ifdef SEQ_MULT_SIGNED_EN
    vecs[4] = '{a: 8'hFD,  b: 8'h05,  s: 1'b1, exp: 16'hFFF1};
    vecs[5] = '{a: 8'h80,  b: 8'h80,  s: 1'b1, exp: 16'h4000};
    vecs[6] = '{a: 8'h7F,  b: 8'h80,  s: 1'b1, exp: 16'hC080};
    vecs[7] = '{a: 8'hFF,  b: 8'hFF,  s: 1'b1, exp: 16'h0001};
    vecs[8] = '{a: 8'h00,  b: 8'h85,  s: 1'b1, exp: 16'h0000};
    vecs[9] = '{a: 8'h05,  b: 8'hFD,  s: 1'b1, exp: 16'hFFF1};
`else
    vecs[4] = '{a: 8'hFD,  b: 8'h05,  s: 1'b1, exp: 16'h04F1};
    vecs[5] = '{a: 8'h80,  b: 8'h80,  s: 1'b1, exp: 16'h4000};
    vecs[6] = '{a: 8'h7F,  b: 8'h80,  s: 1'b1, exp: 16'h3F80};
    vecs[7] = '{a: 8'hFF,  b: 8'hFF,  s: 1'b1, exp: 16'hFE01};
    vecs[8] = '{a: 8'h00,  b: 8'h85,  s: 1'b1, exp: 16'h0000};
    vecs[9] = '{a: 8'h05,  b: 8'hFD,  s: 1'b1, exp: 16'h04F1};
`endif

    // ---- reset state ----
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", {63'b0, rdy8}, 64'd1);
    chk("rst_out_valid", {63'b0, ov8}, 64'd0);
    chk("rst_busy", {63'b0, busy8}, 64'd0);
    chk("rst_product", {48'd0, p8}, 64'd0);
    chk("rst_state", {62'd0, st8}, 64'd0);
    chk("rst_w4_state", {62'd0, st4}, 64'd0);
    chk("rst_w16_state", {62'd0, st16}, 64'd0);
    chk("rst_w4_busy", {63'b0, busy4}, 64'd0);
    chk("rst_w16_busy", {63'b0, busy16}, 64'd0);

    // ---- table-driven 8-bit vectors ----
    for (int i = 0; i < 10; i++) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].s, prod, lat);
      chk($sformatf("vec%0d_product", i), {48'd0, prod}, {48'd0, vecs[i].exp});
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd9);
      @(negedge clk);
      chk($sformatf("vec%0d_out_valid_one_cycle", i), {63'b0, ov8}, 64'd0);
      chk($sformatf("vec%0d_in_ready_after", i), {63'b0, rdy8}, 64'd1);
    end

    // ---- backpressure: 7x6 held, 9x9 offered meanwhile is ignored ----
    or8 = 1'b0;
    op8(8'd7, 8'd6, 1'b0, prod, lat);
    chk("bp_product", {48'd0, prod}, 64'd42);
    chk("bp_latency", 64'(lat), 64'd9);
    for (int i = 0; i < 10; i++) begin
      a8 = 8'd9; b8 = 8'd9; s8 = 1'b0; v8 = 1'b1;
      chk("bp_out_valid_held", {63'b0, ov8}, 64'd1);
      chk("bp_product_held", {48'd0, p8}, 64'd42);
      chk("bp_in_ready_low", {63'b0, rdy8}, 64'd0);
      @(negedge clk);
    end
    v8 = 1'b0;
    or8 = 1'b1;
    @(negedge clk);
    chk("bp_out_valid_drop", {63'b0, ov8}, 64'd0);
    chk("bp_product_stable", {48'd0, p8}, 64'd42);
    chk("bp_in_ready_back", {63'b0, rdy8}, 64'd1);
    op8(8'd9, 8'd9, 1'b0, prod, lat);
    chk("bp_next_product", {48'd0, prod}, 64'd81);
    chk("bp_next_latency", 64'(lat), 64'd9);
    @(negedge clk);

    // ---- reset in the middle of CALC (after step 3 of 8) ----
    a8 = 8'd100; b8 = 8'd100; s8 = 1'b0; v8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v8 = 1'b0;
    chk("mid_busy", {63'b0, busy8}, 64'd1);
    chk("mid_in_ready", {63'b0, rdy8}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_in_ready", {63'b0, rdy8}, 64'd1);
    chk("mid_rst_out_valid", {63'b0, ov8}, 64'd0);
    chk("mid_rst_busy", {63'b0, busy8}, 64'd0);
    chk("mid_rst_product", {48'd0, p8}, 64'd0);
    op8(8'd2, 8'd3, 1'b0, prod, lat);
    chk("mid_next_product", {48'd0, prod}, 64'd6);
    chk("mid_next_latency", 64'(lat), 64'd9);
    @(negedge clk);

    // ---- WIDTH=4 exhaustive unsigned sweep ----
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        op4(4'(x), 4'(y));
      end
    end

    // ---- WIDTH=16 corners plus random unsigned ----
    op16(16'hFFFF, 16'hFFFF);
    op16(16'h8000, 16'h0002);
    op16(16'h0000, 16'hBEEF);
    op16(16'h1234, 16'h0001);
    for (int i = 0; i < 40; i++) begin
      op16(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential shift-add multiplier with valid/ready handshakes on both sides. It computes one WIDTH×WIDTH product in WIDTH compute cycles, trading the combinational partial-product array of the 4-bit multiplier for one adder and a shift register. It sits in the arithmetic-circuits set as the area-efficient, width-generic multiplier for datapaths that tolerate multi-cycle latency. Optional signed (two's-complement) mode is selectable per operation.

## Interface
- WIDTH, 8: operand width in bits, ≥2; product is 2·WIDTH bits.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- is_signed  input  1  1 = two's-complement operands and result; 0 = unsigned.
- out_valid  output  1  product valid, held until taken.
- out_ready  input  1  consumer accepts product.
- product  output  2·WIDTH  result.
- busy  output  1  high in CALC or DONE.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: latch operands and mode, clear accumulator, load step counter with WIDTH, go to CALC.
- Signed mode: latch |a| and |b|, and neg_flag = a[MSB]^b[MSB]. Unsigned: latch raw operands, neg_flag=0.
- CALC: per cycle, if multiplier LSB=1 add shifted multiplicand into 2·WIDTH-bit accumulator; shift multiplicand left 1, multiplier right 1; decrement counter. After the WIDTH-th step go to DONE.
- DONE entry: product = neg_flag ? two's-complement negate(acc) : acc (registered). out_valid=1.
- DONE: hold product and out_valid stable while out_ready=0. On out_valid&&out_ready go to IDLE; out_valid drops next cycle.
- Full-range correctness: -2^(WIDTH-1)·-2^(WIDTH-1) = 2^(2·WIDTH-2) is representable; magnitude of -2^(WIDTH-1) is computed in WIDTH bits without overflow (as unsigned).
- in_valid while busy: ignored, no effect on operation in progress; operands not captured.
- Zero operand: no early termination; still takes full latency; product=0 (never -0 issue since negate(0)=0).
- Reset at any point (including mid-CALC or DONE with out_valid high): abort, go to IDLE, in-flight result discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, product=0; state IDLE.
- Accept edge = edge 0. CALC occupies edges 1..WIDTH; out_valid=1 and product valid in the cycle after edge WIDTH+1 (latency WIDTH+1 edges from accept to out_valid).
- in_ready low from cycle after accept until cycle after output handshake.
- Min initiation interval: WIDTH+3 cycles (accept, WIDTH CALC, DONE, IDLE).
- product changes only on DONE entry or reset.

## Configuration
- SEQ_MULT_SIGNED_EN defined: is_signed honoured as above; magnitude and final negation logic present.
- Not defined: is_signed ignored, all operations unsigned, neg_flag logic and negator removed; the is_signed port remains for pin compatibility.

## Test plan
- WIDTH=8, unsigned 13×11, out_ready=1 -> product=143 (0x008F), out_valid exactly WIDTH+1 edges after accept, one cycle wide.
- WIDTH=8, unsigned 255×255 then 0×200 -> 65025 (0xFE01), then 0.
- WIDTH=8, SEQ_MULT_SIGNED_EN defined: -3×5 -> 0xFFF1; -128×-128 -> 16384 (0x4000); 127×-128 -> 0xC080. Without macro, is_signed=1 on 0xFD×0x05 -> 1265 (0x04F1).
- Backpressure: 7×6 with out_ready=0 for 10 cycles -> out_valid and product=42 held stable, in_ready=0; new in_valid (9×9) during this ignored; after out_ready, next accepted 9×9 -> 81.
- rst asserted mid-CALC (step 3 of 8 on 100×100) -> next cycle IDLE, in_ready=1, out_valid=0, product=0; subsequent 2×3 -> 6.
- WIDTH=4 and WIDTH=16 exhaustive/random unsigned sweep against reference model -> all products match, latency WIDTH+1.
